// File: rtl/bsl_bus_pkg.sv
// Shared types and helpers for the tri-state bus receiver: FSM encoding,
// bus polarity restore and FIFO count width.
package bsl_bus_pkg;

   localparam int unsigned BSL_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } bsl_state_e;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned bsl_cnt_w(input int unsigned depth);
      return 32'($clog2(depth)) + 32'd1;
   endfunction

   // Undo the inverting bus-driver cells when the bus carries ~data.
   function automatic logic [BSL_MAX_W-1:0] bsl_restore(input logic inv,
                                                        input logic [BSL_MAX_W-1:0] bus);
      return inv ? ~bus : bus;
   endfunction

endpackage

// File: rtl/bsl_sync_fifo.sv
// Show-ahead synchronous FIFO: registered head word, valid, full and count.
// Push is ignored when full, pop is ignored when empty.
module bsl_sync_fifo
   import bsl_bus_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [WIDTH-1:0]              wdata_i,
   output logic [WIDTH-1:0]              head_o,
   output logic                          valid_o,
   output logic                          full_o,
   output logic [bsl_cnt_w(DEPTH)-1:0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = bsl_cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_nxt_c;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             full_q, full_d;
   logic             push_c, pop_c;

   // Next-state: pointers, occupancy and the registered head word.
   always_comb begin
      push_c   = push_i & ~full_q;
      pop_c    = pop_i & valid_q;
      rd_nxt_c = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_c ? rd_nxt_c : rd_ptr_q;
      count_d  = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
         count_d = count_q - CNT_W'(1);
      end
      valid_d = (count_d != '0);
      full_d  = (count_d == CNT_W'(DEPTH));
      head_d  = head_q;
      // A single-entry pop that coincides with a push hands over to the new word.
      if (count_d == '0) begin
         head_d = '0;
      end else if (pop_c) begin
         head_d = (count_q == CNT_W'(1)) ? wdata_i : mem_q[rd_nxt_c];
      end else if (!valid_q) begin
         head_d = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset; occupancy decides what is visible.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign full_o  = full_q;
   assign count_o = count_q;

endmodule

// File: rtl/bsl_bus_rx.sv
// Receiver for the shared inverting tri-state bus: 4-phase STB/ACK handshake,
// polarity restore and a show-ahead FIFO toward the core.
module bsl_bus_rx
   import bsl_bus_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter bit          INVERT = 1'b1
) (
   input  logic                          CLK,
   input  logic                          RSTB,
   input  logic [WIDTH-1:0]              BUS_IN,
   input  logic                          BUS_STB,
   output logic                          BUS_ACK,
   output logic [WIDTH-1:0]              RX_DATA,
   output logic                          RX_VALID,
   input  logic                          RX_READY,
   output logic [bsl_cnt_w(DEPTH)-1:0]   RX_COUNT,
   output logic                          PROTO_ERR,
   input  logic                          CLR_ERR
);

   bsl_state_e       state_q, state_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             err_set_c;
   logic             push_c;
   logic             full_c;
   logic [WIDTH-1:0] word_c;

   assign word_c = WIDTH'(bsl_restore(INVERT, BSL_MAX_W'(BUS_IN)));

   // Handshake next-state; a full FIFO parks the strobe in WAIT without ACK.
   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      push_c    = 1'b0;
      err_set_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (BUS_STB) begin
               if (!full_c) begin
                  push_c  = 1'b1;
                  ack_d   = 1'b1;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!BUS_STB) begin
               err_set_c = 1'b1;
               state_d   = ST_IDLE;
            end else if (!full_c) begin
               push_c  = 1'b1;
               ack_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!BUS_STB) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      err_d = err_set_c ? 1'b1 : (CLR_ERR ? 1'b0 : err_q);
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   bsl_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RSTB),
      .push_i  (push_c),
      .pop_i   (RX_READY),
      .wdata_i (word_c),
      .head_o  (RX_DATA),
      .valid_o (RX_VALID),
      .full_o  (full_c),
      .count_o (RX_COUNT)
   );

   assign BUS_ACK   = ack_q;
   assign PROTO_ERR = err_q;

endmodule

// File: tb/tb_bsl_bus_rx.sv
// Scoreboard bench for bsl_bus_rx: an INVERT=1 instance is fully checked, an
// INVERT=0 instance on the same stimulus covers the non-inverting path.
module tb_bsl_bus_rx;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       stb      = 1'b0;
   logic       rx_ready = 1'b0;
   logic       clr_err  = 1'b0;
   logic [7:0] bus_in   = 8'h00;

   logic       ack, valid, err;
   logic [7:0] data;
   logic [2:0] count;
   logic       ack0, valid0, err0;
   logic [7:0] data0;
   logic [2:0] count0;

   int         n_chk = 0;
   int         n_bad = 0;
   logic [7:0] sb_q [$];
   logic       streaming = 1'b0;
   int         max_cnt   = 0;

   always #5 clk = ~clk;

   bsl_bus_rx #(.WIDTH(8), .DEPTH(4), .INVERT(1'b1)) u_dut (
      .CLK(clk), .RSTB(rst_n), .BUS_IN(bus_in), .BUS_STB(stb), .BUS_ACK(ack),
      .RX_DATA(data), .RX_VALID(valid), .RX_READY(rx_ready), .RX_COUNT(count),
      .PROTO_ERR(err), .CLR_ERR(clr_err)
   );

   bsl_bus_rx #(.WIDTH(8), .DEPTH(4), .INVERT(1'b0)) u_dut0 (
      .CLK(clk), .RSTB(rst_n), .BUS_IN(bus_in), .BUS_STB(stb), .BUS_ACK(ack0),
      .RX_DATA(data0), .RX_VALID(valid0), .RX_READY(rx_ready), .RX_COUNT(count0),
      .PROTO_ERR(err0), .CLR_ERR(clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w);
      bus_in = w;
      stb    = 1'b1;
      sb_q.push_back(~w);
      step();
      chk("ack_rise", 32'(ack), 32'd1);
      stb = 1'b0;
      step();
      chk("ack_fall", 32'(ack), 32'd0);
   endtask

   // Consumer side: a pop happens on the next rising edge when valid & ready.
   always @(negedge clk) begin
      if (rst_n && valid && rx_ready) begin
         chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) chk("pop_data", 32'(data), 32'(sb_q.pop_front()));
      end
      if (streaming && int'(count) > max_cnt) max_cnt = int'(count);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_err0", 32'(err0), 32'd0);
      rst_n = 1'b1;
      step();

      // Single word, inverted bus
      bus_in = 8'hA5;
      stb    = 1'b1;
      sb_q.push_back(8'h5A);
      step();
      chk("t1_ack", 32'(ack), 32'd1);
      chk("t1_data", 32'(data), 32'h5A);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_count", 32'(count), 32'd1);
      stb = 1'b0;
      step();
      chk("t1_ack_fall", 32'(ack), 32'd0);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("t1_empty_count", 32'(count), 32'd0);
      chk("t1_empty_valid", 32'(valid), 32'd0);
      chk("t1_empty_data", 32'(data), 32'd0);

      // Fill to DEPTH, then a fifth strobe stalls until a pop frees space
      send_word(8'hFE);
      send_word(8'hFD);
      send_word(8'hFC);
      send_word(8'hFB);
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_head", 32'(data), 32'h01);
      bus_in = 8'hFA;
      stb    = 1'b1;
      step();
      chk("t2_wait_ack0", 32'(ack), 32'd0);
      step();
      chk("t2_wait_ack1", 32'(ack), 32'd0);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("t2_pop_no_ack", 32'(ack), 32'd0);
      chk("t2_pop_count", 32'(count), 32'd3);
      chk("t2_pop_head", 32'(data), 32'h02);
      sb_q.push_back(8'h05);
      step();
      chk("t2_late_ack", 32'(ack), 32'd1);
      chk("t2_late_count", 32'(count), 32'd4);
      stb = 1'b0;
      step();
      chk("t2_ack_fall", 32'(ack), 32'd0);

      // Abort in WAIT raises the sticky error; set beats clear
      bus_in = 8'h77;
      stb    = 1'b1;
      step();
      chk("t3_wait_ack", 32'(ack), 32'd0);
      stb = 1'b0;
      step();
      chk("t3_err_set", 32'(err), 32'd1);
      chk("t3_no_write", 32'(count), 32'd4);
      chk("t3_head", 32'(data), 32'h02);
      step();
      chk("t3_err_sticky", 32'(err), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_err_clr", 32'(err), 32'd0);
      stb = 1'b1;
      step();
      stb     = 1'b0;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_set_wins", 32'(err), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_err_clr2", 32'(err), 32'd0);
      rx_ready = 1'b1;
      repeat (4) step();
      rx_ready = 1'b0;
      chk("t3_drained", 32'(count), 32'd0);
      chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

      // Streaming with the consumer always ready; wraps pointers twice
      rx_ready  = 1'b1;
      max_cnt   = 0;
      streaming = 1'b1;
      for (int i = 0; i < 10; i++) send_word(8'($urandom_range(0, 255)));
      step();
      streaming = 1'b0;
      rx_ready  = 1'b0;
      chk("t4_max_count", 32'(max_cnt), 32'd1);
      chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("t4_count", 32'(count), 32'd0);

      // Asynchronous reset mid-handshake with three words held
      send_word(8'h11);
      send_word(8'h22);
      bus_in = 8'h33;
      stb    = 1'b1;
      step();
      chk("t5_pre_ack", 32'(ack), 32'd1);
      chk("t5_pre_count", 32'(count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ack", 32'(ack), 32'd0);
      chk("t5_rst_valid", 32'(valid), 32'd0);
      chk("t5_rst_count", 32'(count), 32'd0);
      chk("t5_rst_data", 32'(data), 32'd0);
      chk("t5_rst_ack0", 32'(ack0), 32'd0);
      chk("t5_rst_count0", 32'(count0), 32'd0);
      sb_q.delete();
      stb = 1'b0;
      step();
      #3;
      rst_n = 1'b1;
      step();
      chk("t5_post_count", 32'(count), 32'd0);
      bus_in = 8'h3C;
      stb    = 1'b1;
      sb_q.push_back(8'hC3);
      step();
      chk("t5_noinv_data", 32'(data0), 32'h3C);
      chk("t5_noinv_valid", 32'(valid0), 32'd1);
      chk("t5_noinv_ack", 32'(ack0), 32'd1);
      chk("t5_inv_data", 32'(data), 32'hC3);
      stb = 1'b0;
      step();
      chk("t5_noinv_ack_fall", 32'(ack0), 32'd0);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("t5_noinv_empty", 32'(count0), 32'd0);
      chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("t5_err0", 32'(err0), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
